serial_bit_feeder: RTL
======================

// Module: serial_bit_feeder
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the 1-1-1 Mealy sequence detector.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk.
//  x_out drives the detector's x_inp.
//  One-word holding register allows back-to-back words with no idle bit between frames.
// PARAMETERS
//  WIDTH  8  data bits per word; legal range WIDTH >= 2
// PORTS
//  clk          input   1      single clock; all logic on posedge
//  rst          input   1      synchronous, active-high reset
//  din          input   WIDTH  parallel word to serialise
//  din_valid    input   1      din is valid this cycle
//  din_ready    output  1      holding register empty; word is accepted on an edge where valid&&ready
//  x_out        output  1      serial bit to detector x_inp; 0 whenever x_valid=0
//  x_valid      output  1      x_out carries a frame bit this cycle
//  frame_start  output  1      high during the first bit (MSB) of each frame
//  busy         output  1      x_valid || hold_full
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge):
//      state=IDLE, hold_full=0, SR=0, CNT=0.
//      Outputs: x_out=0, x_valid=0, frame_start=0, busy=0, din_ready=1.
//      A word held or mid-shift is discarded. rst has priority over all other events.
//  - din_ready = !hold_full. It is a registered flag, not combinational on din_valid.
//  - Accept: at an edge with din_valid && din_ready, H <= din and hold_full <= 1.
//    If din_valid=1 while din_ready=0, din is ignored and H is unchanged.
//  - FSM states: IDLE, SHIFT, PARITY. PARITY exists only with SER_PARITY_EN.
//  - IDLE:
//      If hold_full: SR <= H, hold_full <= 0, CNT <= 0, go to SHIFT.
//      Otherwise stay in IDLE.
//  - SHIFT:
//      x_out = SR[WIDTH-1] and x_valid = 1. Each edge: SR <= SR<<1, CNT <= CNT+1.
//      On the edge ending bit WIDTH-1:
//        with SER_PARITY_EN -> go to PARITY;
//        otherwise -> reload from H if hold_full (next frame starts next cycle), else go to IDLE.
//  - PARITY: one cycle, x_out = captured parity bit, then the same reload/IDLE decision as above.
//  - Latency: word accepted at edge E0 in IDLE -> MSB is on x_out during the cycle after edge E1.
//    Latency is 2 cycles.
//  - Back-to-back:
//      If the next word is in H by the last-bit edge, frames are contiguous.
//      din_ready goes low while H is full and returns high the cycle after the H->SR transfer.
//      A new word may be accepted during any bit of the current frame.
//  - Simultaneous events: at one edge, an accept can coincide with an H->SR transfer only if
//    hold_full was already 0, which is impossible. So transfer and accept never collide.
//  - x_valid=0 forces x_out=0. Gaps therefore present 0 to the detector and break any 1-run.
//  - CNT width is $clog2(WIDTH+1). No wrap: CNT is cleared at each load.
// CONFIGURATION
//  SER_PARITY_EN
//    Defined: the parity bit ^word is captured at load and appended after the data bits,
//    giving WIDTH+1 bits per frame (even parity over data+parity).
//    Undefined: frame is exactly WIDTH bits, and the PARITY state and its logic are absent.
// TESTING
//  1) rst=1 for 3 cycles, din_valid=1 -> x_valid=0, x_out=0, busy=0, din_ready=1; no word taken.
//  2) Single word 8'b0111_0111 -> after 2-cycle latency x_out = 0,1,1,1,0,1,1,1.
//     x_valid is high for 8 cycles, frame_start on the first bit, and the detector's y_out
//     pulses on bits 3 and 7.
//  3) 8'hFF then 8'h0F with din_valid held -> 16 contiguous valid bits
//     1111_1111_0000_1111, no gap; din_ready low while H is full.
//  4) Hold word 8'hA5 in H, drive din=8'h3C with din_ready=0 -> 8'hA5 is emitted next;
//     8'h3C is not taken until ready.
//  5) rst=1 during bit 4 of 8'hF0 with 8'h55 in H -> next cycle x_valid=0, busy=0, din_ready=1;
//     8'h55 is never emitted.
//  6) SER_PARITY_EN defined, word 8'b0000_0111 -> 9 bits 0,0,0,0,0,1,1,1,1.
//     Without the macro the same word gives 8 bits and x_valid=0 on the 9th cycle.

Source files
------------

// File: rtl/serial_bit_feeder_if.sv
// ============================================================================
//  Module   : serial_bit_feeder_if
//  Brief    : Parallel-word handshake and serial-bit output bundle for serial_bit_feeder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_bit_feeder_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x_out;
   logic             x_valid;
   logic             frame_start;
   logic             busy;

   // master: word producer / bit observer; slave: the feeder itself
   modport master (
      output din, din_valid,
      input  din_ready, x_out, x_valid, frame_start, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, x_out, x_valid, frame_start, busy
   );
endinterface

`default_nettype wire

// File: rtl/serial_bit_feeder.sv
// ============================================================================
//  Module   : serial_bit_feeder
//  Brief    : Parallel-in/serial-out MSB-first feeder with one-word holding register.
//             Optional macro SER_PARITY_EN appends an even-parity bit to every frame.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_bit_feeder #(
   parameter int WIDTH = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   serial_bit_feeder_if.slave bus
);

   localparam int                CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  C_LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1
`ifdef SER_PARITY_EN
      ,
      S_PARITY = 2'd2
`endif
   } state_t;

   state_t             state_q;
   logic               hold_full_q;
   logic [WIDTH-1:0]   h_q;
   logic [WIDTH-1:0]   sr_q;
   logic [CNT_W-1:0]   cnt_q;
`ifdef SER_PARITY_EN
   logic               par_q;
`endif

   logic last_bit;
   logic frame_done;
   logic reload;
   logic x_valid;

   assign last_bit = (state_q == S_SHIFT) && (cnt_q == C_LAST_BIT);

`ifdef SER_PARITY_EN
   assign frame_done = (state_q == S_PARITY);
`else
   assign frame_done = last_bit;
`endif

   // Reloading on the frame's final edge keeps consecutive frames gap-free.
   assign reload = hold_full_q && ((state_q == S_IDLE) || frame_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hold_full_q <= 1'b0;
         h_q         <= '0;
         sr_q        <= '0;
         cnt_q       <= '0;
`ifdef SER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         if (bus.din_valid && !hold_full_q) begin
            h_q         <= bus.din;
            hold_full_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
               sr_q  <= sr_q << 1;
               cnt_q <= cnt_q + 1'b1;
               if (last_bit) begin
`ifdef SER_PARITY_EN
                  state_q <= S_PARITY;
`else
                  state_q <= S_IDLE;
`endif
               end
            end
`ifdef SER_PARITY_EN
            S_PARITY: state_q <= S_IDLE;
`endif
            default: state_q <= S_IDLE;
         endcase

         // Transfer only happens with hold_full set, so it never races an accept.
         if (reload) begin
            sr_q        <= h_q;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            state_q     <= S_SHIFT;
`ifdef SER_PARITY_EN
            par_q       <= ^h_q;
`endif
         end
      end
   end

`ifdef SER_PARITY_EN
   assign x_valid = (state_q == S_SHIFT) || (state_q == S_PARITY);
   assign bus.x_out = ((state_q == S_SHIFT) && sr_q[WIDTH-1]) ||
                      ((state_q == S_PARITY) && par_q);
`else
   assign x_valid   = (state_q == S_SHIFT);
   assign bus.x_out = (state_q == S_SHIFT) && sr_q[WIDTH-1];
`endif

   assign bus.x_valid     = x_valid;
   assign bus.frame_start = (state_q == S_SHIFT) && (cnt_q == '0);
   assign bus.busy        = x_valid || hold_full_q;
   assign bus.din_ready   = !hold_full_q;

endmodule

`default_nettype wire
